// File: rtl/alu_wb_stage.sv
// alu_wb_stage: 2-entry in-order writeback buffer with S/Z/C/V flag register and branch resolution.
module alu_wb_stage #(
  parameter int DEPTH = 2,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_res,
  input  logic         in_s,
  input  logic         in_z,
  input  logic         in_c,
  input  logic         in_v,
  input  logic         in_set_flags,
  input  logic [2:0]   in_rd,
  input  logic         in_we,
  input  logic         in_br,
  input  logic [2:0]   in_cond,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [2:0]   out_rd,
  output logic         out_we,
  output logic         out_br,
  output logic         out_taken,
  output logic         flag_s,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);
  localparam logic [1:0] FULL = 2'(DEPTH);
  logic [W+5:0] mem [DEPTH];
  logic [W+5:0] head;
  logic [3:0]   flags;
  logic [1:0]   cnt;
  logic         wp, rp, acc, rel, cond_true, taken;
  assign in_ready  = cnt != FULL;
  assign out_valid = cnt != 2'd0;
  assign acc = in_valid & in_ready;
  assign rel = out_valid & out_ready;
  assign {flag_s, flag_z, flag_c, flag_v} = flags;
  // Branches resolve against the flags as they stood before this cycle's update.
  always_comb begin
    cond_true = in_cond == 3'd0 ? flag_z :
                in_cond == 3'd1 ? flag_s ^ flag_v :
                in_cond == 3'd2 ? flag_z | (flag_s ^ flag_v) :
                in_cond == 3'd3 ? ~flag_z :
                in_cond == 3'd4 ? 1'b1 :
                in_cond == 3'd5 ? flag_c : 1'b0;
    taken = in_br & cond_true;
  end
  assign head = out_valid ? mem[rp] : '0;
  assign {out_res, out_rd, out_we, out_br, out_taken} = head;
  always_ff @(posedge clk) begin
    if (acc) mem[wp] <= {in_res, in_rd, in_we, in_br, taken};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      cnt   <= 2'd0;
      flags <= 4'd0;
    end else begin
      if (acc) wp <= ~wp;
      if (rel) rp <= ~rp;
      if (acc && in_set_flags) flags <= {in_s, in_z, in_c, in_v};
      cnt <= cnt + 2'(acc) - 2'(rel);
    end
  end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed vectors with hand-computed expectations for alu_wb_stage.
module tb_alu_wb_stage;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_ready;
  logic [15:0] in_res = 0;
  logic        in_s = 0, in_z = 0, in_c = 0, in_v = 0, in_set_flags = 0;
  logic [2:0]  in_rd = 0, in_cond = 0;
  logic        in_we = 0, in_br = 0;
  logic        out_valid, out_ready = 0;
  logic [15:0] out_res;
  logic [2:0]  out_rd;
  logic        out_we, out_br, out_taken;
  logic        flag_s, flag_z, flag_c, flag_v;
  int n_cmp = 0, n_err = 0;

  alu_wb_stage #(.DEPTH(2), .W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_s(in_s), .in_z(in_z), .in_c(in_c), .in_v(in_v), .in_set_flags(in_set_flags),
    .in_rd(in_rd), .in_we(in_we), .in_br(in_br), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd),
    .out_we(out_we), .out_br(out_br), .out_taken(out_taken),
    .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] r, input logic [2:0] d, input logic w, input logic b,
                      input logic [2:0] c, input logic sf, input logic [3:0] f);
    in_valid = 1; in_res = r; in_rd = d; in_we = w; in_br = b; in_cond = c;
    in_set_flags = sf; {in_s, in_z, in_c, in_v} = f;
  endtask

  task automatic idle();
    in_valid = 0; in_set_flags = 0; in_br = 0;
  endtask

  function automatic logic [3:0] flg();
    return {flag_s, flag_z, flag_c, flag_v};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flg(), 4'h0);
    chk("rst_outs", {out_res, out_rd, out_we, out_br, out_taken}, 0);

    push(16'h1234, 3'd3, 1, 0, 3'd0, 1, 4'b0010);
    tick();
    idle();
    chk("t2_valid", out_valid, 1);
    chk("t2_head", {out_res, out_rd, out_we}, {16'h1234, 3'd3, 1'b1});
    chk("t2_flags", flg(), 4'b0010);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("t2_drained", out_valid, 0);

    push(16'h0000, 3'd1, 0, 0, 3'd0, 1, 4'b0100);
    tick();
    push(16'h0040, 3'd0, 0, 1, 3'd0, 0, 4'b0000);
    tick();
    idle();
    chk("t3_full", in_ready, 0);
    chk("t3_cmp_head", {out_br, out_taken, out_we}, 3'b000);
    out_ready = 1;
    tick();
    chk("t3_be_taken", {out_valid, out_br, out_taken}, 3'b111);
    tick();
    out_ready = 0;
    push(16'h0041, 3'd0, 0, 1, 3'd3, 0, 4'b0000);
    tick();
    idle();
    chk("t3_bne_not", {out_br, out_taken}, 2'b10);
    push(16'h0042, 3'd0, 0, 1, 3'd2, 0, 4'b0000);
    out_ready = 1;
    tick();
    idle();
    chk("t3_ble_taken", {out_valid, out_br, out_taken}, 3'b111);
    tick();
    out_ready = 0;
    chk("t3_empty", out_valid, 0);

    push(16'h0001, 3'd2, 1, 0, 3'd0, 1, 4'b1000);
    tick();
    push(16'h0050, 3'd0, 0, 1, 3'd1, 1, 4'b0000);
    tick();
    idle();
    chk("t4_flags_new", flg(), 4'b0000);
    out_ready = 1;
    tick();
    chk("t4_blt_old", {out_res, out_br, out_taken}, {16'h0050, 2'b11});
    tick();
    out_ready = 0;

    push(16'h00A0, 3'd1, 1, 0, 3'd0, 0, 4'b0000);
    tick();
    push(16'h00B0, 3'd2, 1, 0, 3'd0, 0, 4'b0000);
    tick();
    push(16'h00C0, 3'd3, 1, 0, 3'd0, 0, 4'b0000);
    tick();
    chk("t5_held_ready", in_ready, 0);
    chk("t5_head_a", out_res, 16'h00A0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("t5_ready_back", in_ready, 1);
    chk("t5_head_b", out_res, 16'h00B0);
    tick();
    idle();
    chk("t5_stable_b", {out_res, out_rd, in_ready}, {16'h00B0, 3'd2, 1'b0});
    out_ready = 1;
    tick();
    chk("t5_head_c", {out_res, out_rd}, {16'h00C0, 3'd3});
    tick();
    chk("t5_empty", out_valid, 0);
    push(16'h00D0, 3'd4, 1, 0, 3'd0, 0, 4'b0000);
    tick();
    push(16'h00E0, 3'd5, 1, 0, 3'd0, 0, 4'b0000);
    tick();
    idle();
    chk("t5_stream", {out_valid, out_res, in_ready}, {1'b1, 16'h00E0, 1'b1});
    tick();
    out_ready = 0;
    chk("t5_stream_empty", out_valid, 0);

    push(16'h0111, 3'd1, 1, 0, 3'd0, 1, 4'b1111);
    tick();
    push(16'h0222, 3'd2, 1, 0, 3'd0, 1, 4'b1111);
    tick();
    idle();
    chk("t6_pre", {out_valid, in_ready, flg()}, {2'b10, 4'hF});
    #2 reset = 1;
    #1;
    chk("t6_async", {out_valid, in_ready, flg()}, {2'b01, 4'h0});
    #1 reset = 0;
    tick();
    push(16'hBEEF, 3'd5, 1, 0, 3'd0, 0, 4'b0000);
    tick();
    idle();
    chk("t6_after", {out_valid, out_res, out_rd, out_we}, {1'b1, 16'hBEEF, 3'd5, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
